// File: rtl/c3lib_elastic_buf_lcell.sv
// c3lib_elastic_buf_lcell
// Registered valid/ready elastic buffer: WIDTH-bit, DEPTH-entry FIFO on a single
// clock. Handshake outputs are decoded from the occupancy register only, so there
// is no combinational path from in_valid to out_valid or from out_ready to
// in_ready. A pushed word becomes visible the cycle after it is written. The
// flush input empties the buffer without touching the storage array.
module c3lib_elastic_buf_lcell #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;

    // Handshake flags depend on the occupancy register alone.
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);

    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Head of queue; holds a stale entry while the buffer is empty.
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointer and occupancy update; flush overrides any push or pop this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; the array clears only on reset, flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_c3lib_elastic_buf_lcell.sv
// tb_c3lib_elastic_buf_lcell
// Scoreboard bench: the driver issues one transaction per cycle and queues every
// word the buffer must accept; an independent monitor compares the DUT outputs
// against that queue and retires entries as they are consumed downstream.
module tb_c3lib_elastic_buf_lcell;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] exp_q [$];
    int               n_vec = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    bit               chk_en = 1'b0;

    c3lib_elastic_buf_lcell #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // One clock cycle of stimulus. Inputs change 2 time units after the rising
    // edge; the queue is updated late in the cycle, after the monitor has looked,
    // to stand for what the buffer holds once the next edge has passed.
    task automatic cyc(input logic iv, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic fl, input logic rn);
        bit push_ok;
        @(posedge clk);
        #2;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        chk_en    = 1'b1;
        if (!rn) exp_q.delete();
        push_ok = rn && iv && (exp_q.size() != DEPTH);
        n_vec++;
        #6;
        if (!rn || fl) exp_q.delete();
        else if (push_ok) exp_q.push_back(d);
    endtask

    // Monitor: sample on the falling edge, compare, retire consumed words.
    initial begin
        logic [WIDTH-1:0] head;
        int               sz;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                sz = exp_q.size();
                if (!rst_n) begin
                    chk("rst_in_ready", 32'(in_ready), 32'd1);
                    chk("rst_out_valid", 32'(out_valid), 32'd0);
                    chk("rst_count", 32'(count), 32'd0);
                    chk("rst_out_data", 32'(out_data), 32'd0);
                end else begin
                    chk("count", 32'(count), 32'(sz));
                    chk("out_valid", 32'(out_valid), 32'(sz != 0));
                    chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
                    if (sz != 0) begin
                        head = exp_q[0];
                        chk("out_data", 32'(out_data), 32'(head));
                        if (out_ready && !flush) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] d;
        #1 rst_n = 1'b0;

        // Reset held for three cycles with random inputs.
        for (int i = 0; i < 3; i++)
            cyc(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        // Single word: visible the following cycle.
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Fill to capacity, fifth word refused, then drain in order.
        for (int k = 1; k <= 5; k++)
            cyc(1'b1, 8'(k), 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Streaming across several pointer wraps.
        for (int k = 0; k < 20; k++)
            cyc(1'b1, 8'(k), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush wins over a simultaneous push and pop.
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 8'h30 + 8'(k), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Randomised traffic in phases of varying backpressure, with rare
        // flushes and occasional mid-stream resets.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 120; i++) begin
                logic iv, ordy, fl, rn;
                d    = 8'($urandom);
                iv   = ($urandom_range(0, 3) != 0);
                ordy = (ph % 3 == 0) ? ($urandom_range(0, 3) == 0) :
                       (ph % 3 == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom);
                fl   = ($urandom_range(0, 39) == 0);
                rn   = ($urandom_range(0, 149) != 0);
                cyc(iv, d, ordy, fl, rn);
                if (!rn) begin
                    for (int r = 0; r < int'($urandom_range(0, 2)); r++)
                        cyc(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
            end
        end

        // Drain whatever is left and confirm the buffer ends empty.
        for (int k = 0; k < DEPTH + 2; k++)
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("final_count", 32'(count), 32'd0);
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
